// File: rtl/reg_writeback_pkg.sv
// Shared RISC-V pipeline constants and the commit trace record used by the
// writeback stage and its register file read ports.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REGS       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } commit_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Writeback bus: execute-latch outputs in, decode read ports and commit trace out.
interface reg_writeback_if;
    import riscv_pkg::*;

    logic                  stall;
    logic                  wbEn;
    logic [REG_ADDR_W-1:0] wbRd;
    logic [XLEN-1:0]       wbData;
    logic [REG_ADDR_W-1:0] rs1Addr;
    logic [REG_ADDR_W-1:0] rs2Addr;
    logic [XLEN-1:0]       rs1Data;
    logic [XLEN-1:0]       rs2Data;
    logic [31:0]           wbCount;
    logic                  commitValid;
    logic [REG_ADDR_W-1:0] commitRd;
    logic [XLEN-1:0]       commitData;

    modport master (
        output stall, wbEn, wbRd, wbData, rs1Addr, rs2Addr,
        input  rs1Data, rs2Data, wbCount, commitValid, commitRd, commitData
    );

    modport slave (
        input  stall, wbEn, wbRd, wbData, rs1Addr, rs2Addr,
        output rs1Data, rs2Data, wbCount, commitValid, commitRd, commitData
    );

endinterface

// File: rtl/reg_writeback_rf_read_port.sv
// One combinational register file read port: x0 forced to zero, same-cycle
// writeback bypass, otherwise the stored array entry.
module rf_read_port
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0]       i_addr,
    input  logic                        i_bypass_en,
    input  logic [REG_ADDR_W-1:0]       i_wb_rd,
    input  logic [XLEN-1:0]             i_wb_data,
    input  logic [REGS-1:0][XLEN-1:0]   i_regs,
    output logic [XLEN-1:0]             o_data
);

    // Priority: x0, then the in-flight commit, then the array.
    always_comb begin
        o_data = {XLEN{1'b0}};
        if (i_addr == ZERO_REG) begin
            o_data = {XLEN{1'b0}};
        end else if (i_bypass_en && (i_wb_rd == i_addr)) begin
            o_data = i_wb_data;
        end else begin
            o_data = i_regs[i_addr];
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: commits the execute latch into the integer register file once
// per latch advance, serves two bypassed read ports, and keeps a commit trace.
module reg_writeback
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    reg_writeback_if.slave bus
);

    logic [REGS-1:0][XLEN-1:0] r_regs;
    logic [31:0]               r_wb_count;
    commit_t                   r_commit;
    logic                      w_commit;
    logic [XLEN-1:0]           w_rs1_data;
    logic [XLEN-1:0]           w_rs2_data;

    // Reset is folded in so the bypass is also disabled while reset is high.
    assign w_commit = bus.wbEn & ~bus.stall & ~reset & (bus.wbRd != ZERO_REG);

    // Register array update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs <= '0;
        end else if (w_commit) begin
            r_regs[bus.wbRd] <= bus.wbData;
        end
    end

    // Commit counter, wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_count <= 32'd0;
        end else if (w_commit) begin
            r_wb_count <= r_wb_count + 32'd1;
        end
    end

    // Commit trace: valid pulses per commit, rd/data hold between commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_commit <= '0;
        end else begin
            r_commit.valid <= w_commit;
            if (w_commit) begin
                r_commit.rd   <= bus.wbRd;
                r_commit.data <= bus.wbData;
            end
        end
    end

    rf_read_port u_rd_port1 (
        .i_addr      (bus.rs1Addr),
        .i_bypass_en (w_commit),
        .i_wb_rd     (bus.wbRd),
        .i_wb_data   (bus.wbData),
        .i_regs      (r_regs),
        .o_data      (w_rs1_data)
    );

    rf_read_port u_rd_port2 (
        .i_addr      (bus.rs2Addr),
        .i_bypass_en (w_commit),
        .i_wb_rd     (bus.wbRd),
        .i_wb_data   (bus.wbData),
        .i_regs      (r_regs),
        .o_data      (w_rs2_data)
    );

    assign bus.rs1Data     = w_rs1_data;
    assign bus.rs2Data     = w_rs2_data;
    assign bus.wbCount     = r_wb_count;
    assign bus.commitValid = r_commit.valid;
    assign bus.commitRd    = r_commit.rd;
    assign bus.commitData  = r_commit.data;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: table-driven read vectors plus a
// scoreboard of expected commit-trace/counter state after each edge.
module tb_reg_writeback;

    logic clk;
    logic reset;

    reg_writeback_if bus ();

    reg_writeback dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        st;
        logic        en;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] count;
    } trace_t;

    trace_t      sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        m_cv;
    logic [4:0]  m_crd;
    logic [31:0] m_cdata;
    logic [31:0] m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive, predict post-edge trace, check reads mid-cycle, check trace after the edge.
    task automatic cycle(input logic rst, input logic st, input logic en,
                         input logic [4:0] rd, input logic [31:0] d,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2, input string tag);
        trace_t t;
        logic   cm;
        reset       = rst;
        bus.stall   = st;
        bus.wbEn    = en;
        bus.wbRd    = rd;
        bus.wbData  = d;
        bus.rs1Addr = a1;
        bus.rs2Addr = a2;
        cm = en & ~st & ~rst & (rd != 5'd0);
        if (rst) begin
            m_cv = 1'b0; m_crd = 5'd0; m_cdata = 32'd0; m_count = 32'd0;
        end else begin
            m_cv = cm;
            if (cm) begin
                m_crd   = rd;
                m_cdata = d;
                m_count = m_count + 32'd1;
            end
        end
        sb.push_back('{m_cv, m_crd, m_cdata, m_count});
        @(negedge clk);
        check({tag, ".rs1Data"}, bus.rs1Data, e1);
        check({tag, ".rs2Data"}, bus.rs2Data, e2);
        @(posedge clk);
        #1;
        t = sb.pop_front();
        check({tag, ".commitValid"}, {31'd0, bus.commitValid}, {31'd0, t.valid});
        check({tag, ".commitRd"},    {27'd0, bus.commitRd},    {27'd0, t.rd});
        check({tag, ".commitData"},  bus.commitData, t.data);
        check({tag, ".wbCount"},     bus.wbCount,    t.count);
    endtask

    vec_t vecs[$];

    initial begin
        //                rst   st    en    rd     data           a1     a2     exp1           exp2
        vecs.push_back('{1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 5'd5,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd5,  32'h0,        32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd5,  32'h0,        32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd5,  32'h0,        32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 5'd9,  32'hA5A5A5A5, 5'd9,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 5'd9,  32'h0,        5'd9,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 5'd0,  32'h00001234, 5'd0,  5'd0,  32'h0,        32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd9,  32'h0,        32'hA5A5A5A5});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 5'd7,  32'h00000011, 5'd7,  5'd7,  32'h00000011, 32'h00000011});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 5'd7,  32'h00000022, 5'd7,  5'd7,  32'h00000022, 32'h00000022});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 5'd7,  32'h0,        5'd7,  5'd7,  32'h00000022, 32'h00000022});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFF0000, 5'd31, 5'd7,  32'hFFFF0000, 32'h00000022});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 5'd1,  32'h00000001, 5'd31, 5'd1,  32'hFFFF0000, 32'h00000001});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 5'd3,  32'h00000055, 5'd3,  5'd5,  32'h0,        32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 5'd3,  32'h0,        5'd3,  5'd5,  32'h0,        32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'h0,        32'h0});

        m_cv = 1'b0; m_crd = 5'd0; m_cdata = 32'd0; m_count = 32'd0;
        reset = 1'b1;
        bus.stall = 1'b0; bus.wbEn = 1'b0; bus.wbRd = 5'd0; bus.wbData = 32'd0;
        bus.rs1Addr = 5'd0; bus.rs2Addr = 5'd0;
        @(posedge clk);
        #1;

        cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, "reset");
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'(2*i), 5'(2*i+1), 32'd0, 32'd0,
                  $sformatf("rst_read%0d", i));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].st, vecs[i].en, vecs[i].rd, vecs[i].d,
                  vecs[i].a1, vecs[i].a2, vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));
        end

        // Counter wrap: preload the counter to all-ones during a stalled cycle.
        bus.stall = 1'b1;
        bus.wbEn  = 1'b1;
        @(negedge clk);
        force dut.r_wb_count = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        release dut.r_wb_count;
        m_cv    = 1'b0;
        m_count = 32'hFFFFFFFF;
        cycle(1'b0, 1'b0, 1'b1, 5'd2, 32'h00000077, 5'd2, 5'd0, 32'h00000077, 32'h0, "wrap");
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd7, 32'h00000077, 32'h0, "wrap_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
